// File: rtl/dmem_responder.sv
// Data-memory responder for the execute-stage load/store bus.
// Word-organised array with byte-enable stores that commit at the accept edge,
// and load reads taken from the array before that edge's write. Every accepted
// request (load, store or erroring) produces exactly one response, in order,
// LATENCY cycles after it was presented. Outputs come straight from the last
// pipeline register, so no combinational path runs from request to response.
module dmem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  proc2Dmem_command,
  input  logic [1:0]  proc2Dmem_size,
  input  logic [31:0] proc2Dmem_addr,
  input  logic [31:0] proc2Dmem_data,
  output logic        Dmem2proc_valid,
  output logic        Dmem2proc_is_load,
  output logic [31:0] Dmem2proc_data,
  output logic        Dmem2proc_error,
  output logic [3:0]  Dmem2proc_outstanding
);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  localparam logic [1:0] SZ_BYTE   = 2'd0;
  localparam logic [1:0] SZ_HALF   = 2'd1;
  localparam logic [1:0] SZ_WORD   = 2'd2;

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef struct packed {
    logic        valid;
    logic        is_load;
    logic        error;
    logic [31:0] data;
  } rsp_t;

  logic [31:0]      mem [MEM_WORDS];
  rsp_t             pipe [LATENCY];
  logic [3:0]       outstanding;

  logic             accept;
  logic             is_load;
  logic             req_error;
  logic             misaligned;
  logic             out_of_range;
  logic             do_write;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      rd_word;
  logic [31:0]      rd_shift;
  logic [31:0]      rd_data;
  logic [3:0]       byte_en;
  logic [31:0]      wr_data;
  rsp_t             rsp_new;

  assign accept       = !reset && (proc2Dmem_command != BUS_NONE);
  assign is_load      = (proc2Dmem_command == BUS_LOAD);
  assign word_idx     = proc2Dmem_addr[IDX_W+1:2];
  assign out_of_range = ({2'b00, proc2Dmem_addr[31:2]} >= 32'(MEM_WORDS));
  assign req_error    = misaligned || out_of_range;
  assign do_write     = accept && (proc2Dmem_command == BUS_STORE) && !req_error;
  assign rd_word      = mem[word_idx];

  // Alignment/size legality and lane steering for both directions.
  always_comb begin
    misaligned = 1'b0;
    byte_en    = 4'b0000;
    wr_data    = proc2Dmem_data;
    rd_shift   = rd_word;
    rd_data    = rd_word;
    case (proc2Dmem_size)
      SZ_BYTE: begin
        byte_en  = 4'b0001 << proc2Dmem_addr[1:0];
        wr_data  = {4{proc2Dmem_data[7:0]}};
        rd_shift = rd_word >> {proc2Dmem_addr[1:0], 3'b000};
        rd_data  = {24'h0, rd_shift[7:0]};
      end
      SZ_HALF: begin
        misaligned = proc2Dmem_addr[0];
        byte_en    = proc2Dmem_addr[1] ? 4'b1100 : 4'b0011;
        wr_data    = {2{proc2Dmem_data[15:0]}};
        rd_shift   = rd_word >> {proc2Dmem_addr[1], 4'b0000};
        rd_data    = {16'h0, rd_shift[15:0]};
      end
      SZ_WORD: begin
        misaligned = (proc2Dmem_addr[1:0] != 2'b00);
        byte_en    = 4'b1111;
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

  // Response entry for this cycle's request; payload stays zero unless it is a good load.
  always_comb begin
    rsp_new         = '0;
    rsp_new.valid   = accept;
    rsp_new.is_load = accept && is_load;
    rsp_new.error   = accept && req_error;
    if (accept && is_load && !req_error) begin
      rsp_new.data = rd_data;
    end
  end

  // Array write at the accept edge; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (!reset && do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Fixed-latency response shift register; reset drops anything in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < LATENCY; k++) begin
        pipe[k] <= '0;
      end
    end else begin
      pipe[0] <= rsp_new;
      for (int k = 1; k < LATENCY; k++) begin
        pipe[k] <= pipe[k-1];
      end
    end
  end

  // Requests accepted but not yet emitted; bounded by LATENCY by construction.
  always_ff @(posedge clock) begin
    if (reset) begin
      outstanding <= 4'd0;
    end else begin
      outstanding <= outstanding + {3'b000, accept} - {3'b000, pipe[LATENCY-1].valid};
    end
  end

  assign Dmem2proc_valid       = pipe[LATENCY-1].valid;
  assign Dmem2proc_is_load     = pipe[LATENCY-1].is_load;
  assign Dmem2proc_error       = pipe[LATENCY-1].error;
  assign Dmem2proc_data        = pipe[LATENCY-1].data;
  assign Dmem2proc_outstanding = outstanding;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one LATENCY=2 instance and one LATENCY=1
// instance. Stimulus pushes the expected response (with the cycle it is due);
// per-instance monitors pop and compare on every valid response and also check
// the outstanding count against the scoreboard contents every cycle.
module tb_dmem_responder;

  localparam logic [1:0] NONE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] STORE = 2'd2;
  localparam logic [1:0] BYTE  = 2'd0;
  localparam logic [1:0] HALF  = 2'd1;
  localparam logic [1:0] WORD  = 2'd2;
  localparam logic [1:0] DBL   = 2'd3;
  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  typedef struct {
    int          due;
    int          acc;
    logic        is_load;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_a, reset_b;
  logic [1:0]  cmd_a, size_a, cmd_b, size_b;
  logic [31:0] addr_a, data_a, addr_b, data_b;
  logic        valid_a, is_load_a, err_a, valid_b, is_load_b, err_b;
  logic [31:0] rdata_a, rdata_b;
  logic [3:0]  out_a, out_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   peak_a = 0;
  int   resp_b = 0;
  bit   mon_en = 0;

  dmem_responder #(.MEM_WORDS(1024), .LATENCY(LAT_A)) dut_a (
    .clock(clock), .reset(reset_a),
    .proc2Dmem_command(cmd_a), .proc2Dmem_size(size_a),
    .proc2Dmem_addr(addr_a), .proc2Dmem_data(data_a),
    .Dmem2proc_valid(valid_a), .Dmem2proc_is_load(is_load_a),
    .Dmem2proc_data(rdata_a), .Dmem2proc_error(err_a),
    .Dmem2proc_outstanding(out_a)
  );

  dmem_responder #(.MEM_WORDS(1024), .LATENCY(LAT_B)) dut_b (
    .clock(clock), .reset(reset_b),
    .proc2Dmem_command(cmd_b), .proc2Dmem_size(size_b),
    .proc2Dmem_addr(addr_b), .proc2Dmem_data(data_b),
    .Dmem2proc_valid(valid_b), .Dmem2proc_is_load(is_load_b),
    .Dmem2proc_data(rdata_b), .Dmem2proc_error(err_b),
    .Dmem2proc_outstanding(out_b)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the LATENCY=2 instance.
  always @(negedge clock) begin
    int   pend;
    exp_t e;
    if (mon_en) begin
      pend = 0;
      foreach (q_a[i]) if (q_a[i].acc <= cyc) pend++;
      chk("a_outstanding", 32'(out_a), 32'(pend));
      if (int'(out_a) > peak_a) peak_a = int'(out_a);
      if (q_a.size() > 0 && q_a[0].due < cyc) begin
        chk("a_missing_response", 32'(cyc), 32'(q_a[0].due));
        void'(q_a.pop_front());
      end
      if (valid_a) begin
        if (q_a.size() == 0) begin
          chk("a_unexpected_response", 32'(valid_a), 32'd0);
        end else begin
          e = q_a.pop_front();
          chk("a_due_cycle", 32'(cyc), 32'(e.due));
          chk("a_is_load", 32'(is_load_a), 32'(e.is_load));
          chk("a_error", 32'(err_a), 32'(e.err));
          chk("a_data", rdata_a, e.data);
        end
      end
    end
  end

  // Monitor for the LATENCY=1 instance.
  always @(negedge clock) begin
    int   pend;
    exp_t e;
    if (mon_en) begin
      pend = 0;
      foreach (q_b[i]) if (q_b[i].acc <= cyc) pend++;
      chk("b_outstanding", 32'(out_b), 32'(pend));
      if (q_b.size() > 0 && q_b[0].due < cyc) begin
        chk("b_missing_response", 32'(cyc), 32'(q_b[0].due));
        void'(q_b.pop_front());
      end
      if (valid_b) begin
        resp_b++;
        if (q_b.size() == 0) begin
          chk("b_unexpected_response", 32'(valid_b), 32'd0);
        end else begin
          e = q_b.pop_front();
          chk("b_due_cycle", 32'(cyc), 32'(e.due));
          chk("b_is_load", 32'(is_load_b), 32'(e.is_load));
          chk("b_error", 32'(err_b), 32'(e.err));
          chk("b_data", rdata_b, e.data);
        end
      end
    end
  end

  task automatic issue_a(input logic [1:0] c, input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] d, input logic e_err, input logic [31:0] e_data);
    exp_t e;
    cmd_a = c; size_a = s; addr_a = a; data_a = d;
    e.due = cyc + LAT_A; e.acc = cyc + 1;
    e.is_load = (c == LOAD); e.err = e_err; e.data = e_data;
    q_a.push_back(e);
    @(posedge clock); #1;
    cmd_a = NONE;
  endtask

  task automatic issue_b(input logic [1:0] c, input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] d, input logic e_err, input logic [31:0] e_data);
    exp_t e;
    cmd_b = c; size_b = s; addr_b = a; data_b = d;
    e.due = cyc + LAT_B; e.acc = cyc + 1;
    e.is_load = (c == LOAD); e.err = e_err; e.data = e_data;
    q_b.push_back(e);
    @(posedge clock); #1;
    cmd_b = NONE;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    if (q_a.size() != 0 || q_b.size() != 0) begin
      chk("drain_timeout", 32'(q_a.size() + q_b.size()), 32'd0);
      q_a.delete();
      q_b.delete();
    end
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    cmd_a = NONE; size_a = WORD; addr_a = '0; data_a = '0;
    cmd_b = NONE; size_b = WORD; addr_b = '0; data_b = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("a_reset_valid", 32'(valid_a), 32'd0);
    chk("a_reset_data", rdata_a, 32'd0);
    chk("a_reset_error", 32'(err_a), 32'd0);
    chk("a_reset_outstanding", 32'(out_a), 32'd0);
    chk("b_reset_valid", 32'(valid_b), 32'd0);
    chk("b_reset_outstanding", 32'(out_b), 32'd0);
    reset_a = 1'b0; reset_b = 1'b0;
    mon_en = 1'b1;

    // Store then load on the next cycle.
    issue_a(STORE, WORD, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0);
    issue_a(LOAD,  WORD, 32'h100, 32'h0,       1'b0, 32'hDEADBEEF);

    // Byte store then mixed-size loads of the merged word.
    issue_a(STORE, BYTE, 32'h102, 32'h0000005A, 1'b0, 32'h0);
    issue_a(LOAD,  BYTE, 32'h102, 32'h0,        1'b0, 32'h0000005A);
    issue_a(LOAD,  HALF, 32'h102, 32'h0,        1'b0, 32'h0000DE5A);
    issue_a(LOAD,  WORD, 32'h100, 32'h0,        1'b0, 32'hDE5ABEEF);

    // Error cases; the erroring store must not disturb the array.
    issue_a(LOAD,  HALF, 32'h101,  32'h0,       1'b1, 32'h0);
    issue_a(STORE, WORD, 32'h102,  32'hFFFFFFFF, 1'b1, 32'h0);
    issue_a(LOAD,  WORD, 32'h1000, 32'h0,       1'b1, 32'h0);
    issue_a(LOAD,  DBL,  32'h100,  32'h0,       1'b1, 32'h0);
    issue_a(STORE, BYTE, 32'h1003, 32'h11,      1'b1, 32'h0);
    issue_a(LOAD,  WORD, 32'h100,  32'h0,       1'b0, 32'hDE5ABEEF);

    // Lane steering with junk in the unused store-data bits; last legal word.
    issue_a(STORE, WORD, 32'h104, 32'h11223344, 1'b0, 32'h0);
    issue_a(STORE, HALF, 32'h106, 32'hFFFF9988, 1'b0, 32'h0);
    issue_a(STORE, BYTE, 32'h105, 32'hFFFFFF55, 1'b0, 32'h0);
    issue_a(LOAD,  WORD, 32'h104, 32'h0,        1'b0, 32'h99885544);
    issue_a(LOAD,  HALF, 32'h104, 32'h0,        1'b0, 32'h00005544);
    issue_a(LOAD,  BYTE, 32'h107, 32'h0,        1'b0, 32'h00000099);
    issue_a(STORE, WORD, 32'hFFC, 32'hCAFEF00D, 1'b0, 32'h0);
    issue_a(LOAD,  HALF, 32'hFFE, 32'h0,        1'b0, 32'h0000CAFE);
    drain();

    // Back-to-back loads of preloaded words.
    issue_a(STORE, WORD, 32'h0, 32'd1, 1'b0, 32'h0);
    issue_a(STORE, WORD, 32'h4, 32'd2, 1'b0, 32'h0);
    issue_a(STORE, WORD, 32'h8, 32'd3, 1'b0, 32'h0);
    drain();
    peak_a = 0;
    issue_a(LOAD, WORD, 32'h0, 32'h0, 1'b0, 32'd1);
    issue_a(LOAD, WORD, 32'h4, 32'h0, 1'b0, 32'd2);
    issue_a(LOAD, WORD, 32'h8, 32'h0, 1'b0, 32'd3);
    drain();
    chk("a_outstanding_peak", 32'(peak_a), 32'd2);

    // Reset with a load in flight and a store presented during reset.
    issue_a(LOAD, WORD, 32'h100, 32'h0, 1'b0, 32'hDE5ABEEF);
    reset_a = 1'b1;
    cmd_a = STORE; size_a = WORD; addr_a = 32'h100; data_a = 32'h12345678;
    @(posedge clock); #1;
    q_a.delete();
    reset_a = 1'b0;
    cmd_a = NONE;
    chk("a_midreset_valid", 32'(valid_a), 32'd0);
    chk("a_midreset_outstanding", 32'(out_a), 32'd0);
    repeat (4) @(posedge clock);
    #1;
    issue_a(LOAD, WORD, 32'h100, 32'h0, 1'b0, 32'hDE5ABEEF);
    drain();

    // LATENCY=1: alternating store/load, each load sees the prior store.
    resp_b = 0;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] v;
      v = 32'hA5000000 + 32'(k) * 32'h00010101;
      issue_b(STORE, WORD, 32'h200, v,     1'b0, 32'h0);
      issue_b(LOAD,  WORD, 32'h200, 32'h0, 1'b0, v);
    end
    drain();
    chk("b_response_count", 32'(resp_b), 32'd8);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d required finish", cyc);
    $fatal(1);
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the load/store bus driven by the execute stage: `*2Dmem_command`, `*2Dmem_size`, `*2Dmem_addr` and `*2Dmem_data`.
- Holds a word-organised data array and accepts at most one request per cycle with no backpressure.
- Performs stores in the accept cycle.
- Returns load data (and store acks) in order, through a fixed-latency response pipeline.
- Load data is right-justified and zero-extended; the execute stage applies sign extension.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the array; legal word index is 0..MEM_WORDS-1.
- LATENCY, 2, cycles from accept edge to response; legal range 1..8.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- proc2Dmem_command  in  2  BUS_NONE / BUS_LOAD / BUS_STORE.
- proc2Dmem_size  in  MEM_SIZE  BYTE=0, HALF=1, WORD=2, DOUBLE=3 (DOUBLE is unsupported).
- proc2Dmem_addr  in  XLEN  byte address.
- proc2Dmem_data  in  XLEN  store data, right-justified (byte in [7:0], half in [15:0]).
- Dmem2proc_valid  out  1  response valid, one cycle per accepted request.
- Dmem2proc_is_load  out  1  response belongs to a load (0 = store ack).
- Dmem2proc_data  out  XLEN  load data, right-justified and zero-extended; 0 for stores and errors.
- Dmem2proc_error  out  1  request was misaligned, out of range, or DOUBLE.
- Dmem2proc_outstanding  out  4  number of accepted requests not yet responded.

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - All outputs read 0 and all response-pipeline valids clear; the outstanding count returns to 0.
  - Array contents are not reset.
  - A request presented in a reset cycle is ignored; a store in that cycle does not write.
  - Responses in flight when reset asserts are dropped and never emitted.
- Accept: any cycle with reset=0 and command != BUS_NONE accepts the request. No stall exists.
- Error check (combinational on the request):
  - Error if size=DOUBLE.
  - Error if HALF and addr[0]=1.
  - Error if WORD and addr[1:0]!=0.
  - Error if word index addr[XLEN-1:2] >= MEM_WORDS.
  - An erroring store does not write the array.
- Stores:
  - Written at the accept edge using byte enables.
  - BYTE writes lane addr[1:0] with data[7:0].
  - HALF writes lanes addr[1]*2 and addr[1]*2+1 with data[15:0].
  - WORD writes all four lanes.
  - Other lanes are unchanged.
- Loads:
  - The array word is read in the accept cycle, before that edge's write. The bus carries a single command per cycle, so no same-cycle load/store conflict exists.
  - Read-after-write: a store accepted at cycle t is visible to a load accepted at t+1 or later.
  - Extraction at accept: BYTE gives word>>(8*addr[1:0]) masked to 8 bits; HALF gives word>>(16*addr[1]) masked to 16 bits; WORD passes the word through.
- Response pipeline:
  - LATENCY stages, each holding {valid, is_load, error, data}.
  - A request accepted on edge t yields a response with Dmem2proc_valid=1 for exactly the cycle following edge t+LATENCY-1, i.e. LATENCY cycles after the request cycle.
  - Order is strictly FIFO; back-to-back requests give back-to-back responses.
  - The response for an erroring request has error=1 and data=0.
- Outstanding counter:
  - +1 on accept, -1 on response emission; both in the same cycle leaves it unchanged.
  - Maximum value is LATENCY; it never wraps.
- Outputs are registered, taken from the final pipeline stage. No combinational path exists from request inputs to outputs.

Test Plan:
- WORD store 0xDEADBEEF @0x100, then WORD load @0x100 on the next cycle (LATENCY=2) -> load response valid 2 cycles after its request, data=0xDEADBEEF, is_load=1, error=0; the store ack precedes it by one cycle.
- After the above, BYTE store 0x5A @0x102, then loads BYTE @0x102 / HALF @0x102 / WORD @0x100 -> 0x0000005A, 0x0000DE5A, 0xDE5ABEEF.
- HALF load @0x101, WORD store @0x102, WORD load @(MEM_WORDS*4) -> three responses with error=1 and data=0; a WORD load @0x100 afterwards still returns 0xDE5ABEEF.
- Back-to-back loads @0x0, @0x4, @0x8 with preloaded 1, 2, 3 -> responses in three consecutive cycles carrying 1, 2, 3; outstanding peaks at 2 (LATENCY=2).
- Load @0x100 accepted, then reset asserted for 1 cycle while a WORD store 0x12345678 @0x100 is presented -> no response emitted, outstanding=0, and a later load @0x100 returns 0xDE5ABEEF.
- LATENCY=1 build: alternating store/load @0x200 every cycle for 8 cycles -> each load returns the previous store's data, and exactly one response cycle occurs per request.
